// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and pipeline-control response bundle for hazard_scoreboard.
// master = pipeline/decode side, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int ADDR_W  = 4,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH)
);
    logic                      dec_valid;
    logic                      dec_we;
    logic                      dec_is_load;
    logic [ADDR_W-1:0]         dec_wa;
    logic [NUM_SRC*ADDR_W-1:0] dec_ra;
    logic [NUM_SRC-1:0]        dec_ra_used;
    logic                      br_taken_e;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

    modport master (
        output dec_valid, dec_we, dec_is_load, dec_wa, dec_ra, dec_ra_used, br_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_sel
    );

    modport slave (
        input  dec_valid, dec_we, dec_is_load, dec_wa, dec_ra, dec_ra_used, br_taken_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_sel
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard tracking in-flight destination tags over DEPTH post-decode stages.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
    parameter int ADDR_W   = 4,
    parameter int NUM_SRC  = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int PC_REG   = 15,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

    logic [DEPTH-1:0]          st_valid;
    logic [DEPTH-1:0]          st_we;
    logic [DEPTH-1:0]          st_load;
    logic [ADDR_W-1:0]         st_wa [DEPTH];
    logic [NUM_SRC*ADDR_W-1:0] e_ra;
    logic [NUM_SRC-1:0]        e_ra_used;

    logic                      lu;
    logic                      stall;
    logic                      flush_e;
    logic                      flush_d;
    logic [NUM_SRC*SEL_W-1:0]  fwd;

    always_comb begin
        lu = 1'b0;
        for (int unsigned j = 0; j < LOAD_LAT; j++) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (hz.dec_valid && st_valid[j] && st_we[j] && st_load[j] &&
                    st_wa[j] != PC_A && hz.dec_ra_used[s] &&
                    st_wa[j] == hz.dec_ra[s*ADDR_W +: ADDR_W])
                    lu = 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer overwrites the select.
    always_comb begin
        fwd = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
                if (st_valid[i] && st_we[i] && st_wa[i] != PC_A && e_ra_used[s] &&
                    st_wa[i] == e_ra[s*ADDR_W +: ADDR_W] &&
                    (!st_load[i] || i >= LOAD_LAT + 1))
                    fwd[s*SEL_W +: SEL_W] = SEL_W'(i);
            end
        end
    end

    // A taken branch squashes the younger instructions instead of holding them.
    assign stall      = lu & ~hz.br_taken_e & ~reset;
    assign flush_e    = (lu | hz.br_taken_e) & ~reset;
    assign flush_d    = hz.br_taken_e & ~reset;
    assign hz.stall_f = stall;
    assign hz.stall_d = stall;
    assign hz.flush_e = flush_e;
    assign hz.flush_d = flush_d;
    assign hz.fwd_sel = reset ? '0 : fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid  <= '0;
            st_we     <= '0;
            st_load   <= '0;
            e_ra      <= '0;
            e_ra_used <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                st_wa[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_we[i]    <= st_we[i-1];
                st_load[i]  <= st_load[i-1];
                st_wa[i]    <= st_wa[i-1];
            end
            if (flush_e) begin
                st_valid[0] <= 1'b0;
                st_we[0]    <= 1'b0;
                st_load[0]  <= 1'b0;
                st_wa[0]    <= '0;
                e_ra        <= '0;
                e_ra_used   <= '0;
            end else begin
                st_valid[0] <= hz.dec_valid;
                st_we[0]    <= hz.dec_we;
                st_load[0]  <= hz.dec_is_load;
                st_wa[0]    <= hz.dec_wa;
                e_ra        <= hz.dec_ra;
                e_ra_used   <= hz.dec_ra_used;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_d && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: default DUT plus a DEPTH=4/LOAD_LAT=2 DUT.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    hazard_scoreboard_if #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(3)) if0 ();
    hazard_scoreboard_if #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(4)) if1 ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] ps0, pf0, ps1, pf1;
`endif

    hazard_scoreboard #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(3), .LOAD_LAT(1), .PC_REG(15)) u0 (
        .clk(clk), .reset(rst0), .hz(if0)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(ps0), .perf_flush_cnt(pf0)
`endif
    );

    hazard_scoreboard #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2), .PC_REG(15)) u1 (
        .clk(clk), .reset(rst1), .hz(if1)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
    );

    typedef struct {
        int         dut;
        logic [3:0] ctl;   // {stall_f, stall_d, flush_d, flush_e}
        logic [5:0] fwd;   // {src2, src1, src0}
        int         ps;
        int         pf;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] act_c;
    logic [5:0] act_f;

    localparam logic [3:0] C0  = 4'b0000;
    localparam logic [3:0] CLU = 4'b1101;
    localparam logic [3:0] CBR = 4'b0011;

    task automatic step(input int dut, input logic rst, input logic v, input logic we,
                        input logic ld, input logic [3:0] wa, input logic [3:0] ra0,
                        input logic [3:0] ra1, input logic [2:0] used, input logic br,
                        input logic [3:0] ctl, input logic [5:0] fwd, input string name,
                        input int ps = -1, input int pf = -1);
        exp_t x;
        if (dut == 0) begin
            rst0 = rst;
            if0.dec_valid = v; if0.dec_we = we; if0.dec_is_load = ld; if0.dec_wa = wa;
            if0.dec_ra = {4'd0, ra1, ra0}; if0.dec_ra_used = used; if0.br_taken_e = br;
        end else begin
            rst1 = rst;
            if1.dec_valid = v; if1.dec_we = we; if1.dec_is_load = ld; if1.dec_wa = wa;
            if1.dec_ra = {4'd0, ra1, ra0}; if1.dec_ra_used = used; if1.br_taken_e = br;
        end
        x.dut = dut; x.ctl = ctl; x.fwd = fwd; x.ps = ps; x.pf = pf; x.name = name;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int dut, input logic rst, input logic [3:0] ctl,
                       input logic [5:0] fwd, input string name);
        step(dut, rst, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 0, ctl, fwd, name);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                act_c = {if0.stall_f, if0.stall_d, if0.flush_d, if0.flush_e};
                act_f = if0.fwd_sel;
            end else begin
                act_c = {if1.stall_f, if1.stall_d, if1.flush_d, if1.flush_e};
                act_f = if1.fwd_sel;
            end
            tests++;
            if (act_c !== e.ctl || act_f !== e.fwd) begin
                fails++;
                $display("FAIL %s (dut%0d): ctl=%b fwd=%b, expected ctl=%b fwd=%b",
                         e.name, e.dut, act_c, act_f, e.ctl, e.fwd);
            end
`ifdef HAZ_PERF_CNT_EN
            if (e.ps >= 0) begin
                tests++;
                if ((e.dut == 0 ? ps0 : ps1) !== 32'(e.ps) ||
                    (e.dut == 0 ? pf0 : pf1) !== 32'(e.pf)) begin
                    fails++;
                    $display("FAIL %s_perf (dut%0d): stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                             e.name, e.dut, (e.dut == 0 ? ps0 : ps1),
                             (e.dut == 0 ? pf0 : pf1), e.ps, e.pf);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        if0.dec_valid = 0; if0.dec_we = 0; if0.dec_is_load = 0; if0.dec_wa = '0;
        if0.dec_ra = '0; if0.dec_ra_used = '0; if0.br_taken_e = 0;
        if1.dec_valid = 0; if1.dec_we = 0; if1.dec_is_load = 0; if1.dec_wa = '0;
        if1.dec_ra = '0; if1.dec_ra_used = '0; if1.br_taken_e = 0;
        @(posedge clk);
        #1;

        // Default config: DEPTH=3, LOAD_LAT=1
        nop (0, 1, C0, 6'b000000, "reset");
        step(0, 0, 1, 1, 0, 4'd1, 4'd8, 4'd9, 3'b011, 0, C0, 6'b000000, "add_r1");
        step(0, 0, 1, 1, 0, 4'd2, 4'd1, 4'd3, 3'b011, 0, C0, 6'b000000, "dep_in_d");
        nop (0, 0, C0, 6'b000001, "fwd_m");
        step(0, 0, 1, 1, 0, 4'd1, 4'd8, 4'd9, 3'b011, 0, C0, 6'b000000, "add_r1_b");
        nop (0, 0, C0, 6'b000000, "no_false_match");
        step(0, 0, 1, 1, 0, 4'd4, 4'd1, 4'd1, 3'b011, 0, C0, 6'b000000, "sub_in_d");
        nop (0, 0, C0, 6'b001010, "fwd_w");
        step(0, 0, 1, 1, 1, 4'd5, 4'd0, 4'd0, 3'b001, 0, C0, 6'b000000, "ldr_in_d");
        step(0, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, CLU, 6'b000000, "lu_stall");
        step(0, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "lu_release");
        nop (0, 0, C0, 6'b000010, "lu_fwd_w");
        step(0, 0, 1, 1, 0, 4'd1, 4'd0, 4'd0, 3'b000, 0, C0, 6'b000000, "mov1");
        step(0, 0, 1, 1, 0, 4'd1, 4'd0, 4'd0, 3'b000, 0, C0, 6'b000000, "mov2");
        step(0, 0, 1, 1, 0, 4'd7, 4'd1, 4'd1, 3'b011, 0, C0, 6'b000000, "add_r7");
        nop (0, 0, C0, 6'b000101, "youngest_wins");
        step(0, 0, 1, 1, 0, 4'd15, 4'd0, 4'd0, 3'b000, 0, C0, 6'b000000, "mov_pc");
        step(0, 0, 1, 1, 0, 4'd3, 4'd15, 4'd15, 3'b011, 0, C0, 6'b000000, "read_pc");
        nop (0, 0, C0, 6'b000000, "pc_no_forward");
        step(0, 0, 1, 1, 1, 4'd5, 4'd0, 4'd0, 3'b001, 0, C0, 6'b000000, "ldr_b");
        step(0, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 1, CBR, 6'b000000, "br_over_lu");
        step(0, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "no_stall_after_br");
        nop (0, 0, C0, 6'b000010, "fwd_after_br");
        step(0, 0, 1, 1, 1, 4'd5, 4'd0, 4'd0, 3'b001, 0, C0, 6'b000000, "ldr_c");
        step(0, 1, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "reset_mid_stall", 1, 1);
        step(0, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "post_reset", 0, 0);
        nop (0, 0, C0, 6'b000000, "post_reset_fwd0");
        step(0, 0, 1, 1, 1, 4'd5, 4'd0, 4'd0, 3'b001, 0, C0, 6'b000000, "ldr_d");
        step(0, 0, 0, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "lu_needs_valid");

        // DEPTH=4, LOAD_LAT=2: two stall cycles, load forwarded from stage 3
        nop (1, 1, C0, 6'b000000, "reset2");
        step(1, 0, 1, 1, 1, 4'd5, 4'd0, 4'd0, 3'b001, 0, C0, 6'b000000, "ldr2");
        step(1, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, CLU, 6'b000000, "lu2_cycle1");
        step(1, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, CLU, 6'b000000, "lu2_cycle2");
        step(1, 0, 1, 1, 0, 4'd6, 4'd5, 4'd2, 3'b011, 0, C0, 6'b000000, "lu2_release");
        nop (1, 0, C0, 6'b000011, "lu2_fwd_stage3");

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined ARM core.
- Replaces the fixed two-source, E/M/W equality-match signals with a registered scoreboard of in-flight destination tags across DEPTH post-decode stages.
- Produces per-source forwarding selects, load-use stall, bubble insertion and branch flush.
- Sits beside the datapath. Driven by decode-stage register fields; drives the stall/flush enables of the pipeline registers and the forwarding muxes.

Parameters:
- ADDR_W, 4, register address width.
- NUM_SRC, 3, number of source operands per instruction (Rn, Rm, Rs/Rd-as-source).
- DEPTH, 3, tracked stages after decode; index 0=E, 1=M, ..., DEPTH-1=W. Minimum 2.
- LOAD_LAT, 1, extra cycles after E before load data is forwardable. Range 1..DEPTH-2.
- PC_REG, 15, register address that is never forwarded (read as PC+8 from the regfile path).
- SEL_W, $clog2(DEPTH), width of each forwarding select.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- dec_valid  input  1  decode stage holds a real instruction
- dec_we  input  1  decode instruction writes a register
- dec_is_load  input  1  decode instruction is LDR
- dec_wa  input  ADDR_W  decode destination register
- dec_ra  input  NUM_SRC*ADDR_W  decode source addresses; source s at [s*ADDR_W +: ADDR_W]
- dec_ra_used  input  NUM_SRC  per-source "operand is actually read"
- br_taken_e  input  1  branch/PC write resolved taken in E
- stall_f  output  1  hold PC register
- stall_d  output  1  hold fetch-to-decode register
- flush_d  output  1  clear fetch-to-decode register
- flush_e  output  1  clear decode-to-execute register (bubble)
- fwd_sel  output  NUM_SRC*SEL_W  per E-stage source: 0=regfile, i=stage i result (1=M ... DEPTH-1=W)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Scoreboard state: per stage i, entry {valid, we, is_load, wa}. Stage 0 additionally holds the E-stage copy of ra/ra_used for all sources.
- Entries for stages 1..DEPTH-1 shift every cycle: stage i <= stage i-1. The entry in stage DEPTH-1 is discarded.
- Stage 0 load: if flush_e, it loads a bubble (valid=0). Otherwise it loads {dec_valid, dec_we, dec_is_load, dec_wa, dec_ra, dec_ra_used}.
- Match(i,s): entry i is valid and has we=1, its wa equals E-source s, E-source s is used, and wa != PC_REG.
- Forwardable(i): i >= 1 and (not is_load or i >= LOAD_LAT+1).
- fwd_sel[s]: the smallest i in 1..DEPTH-1 with Match(i,s) and Forwardable(i), so the youngest producer wins. 0 if none.
- Load-use hazard (lu): any stage j in 0..LOAD_LAT-1 holds a valid, we, is_load entry whose wa (not PC_REG) equals some used dec_ra while dec_valid=1.
- Outputs: stall_f = stall_d = lu & ~br_taken_e. flush_e = lu | br_taken_e. flush_d = br_taken_e.
- Branch priority: a branch overrides the stall. When branch and load-use are both true, the younger instructions are squashed, not held.
- All outputs are combinational from registered state plus decode inputs. There is no added latency.
- Reset: all valid bits cleared. While reset=1 all outputs are 0, and flush_e/flush_d are also gated by ~reset. A reset mid-stall drops the pending hazard; the first cycle after reset has no stall.
- Multi-cycle stall (LOAD_LAT>1): the stall persists naturally while the load walks stages 0..LOAD_LAT-1. The decode inputs are held stable by stall_d.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt counts cycles with stall_d=1.
  - perf_flush_cnt counts cycles with flush_d=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- When undefined: the ports and counters are absent, and the block is otherwise identical.

Test Plan:
- ADD R1 then ADD R2,R1,R3 (defaults) -> second instr in E gets fwd_sel[0]=1 (M). No stall.
- ADD R1; NOP; SUB R4,R1,R1 -> fwd_sel[0]=fwd_sel[1]=2 (W).
- LDR R5,[R0] then ADD R6,R5,R2 -> one cycle of stall_f=stall_d=flush_e=1. Then the ADD reaches E with fwd_sel[0]=2. LOAD_LAT=2, DEPTH=4 -> two stall cycles, then fwd_sel=3.
- Consecutive writes to R1 (MOV R1,#1; MOV R1,#2; ADD R7,R1,R1) -> fwd_sel[0]=1, youngest wins. Writer to R15 followed by reader of R15 -> fwd_sel=0.
- LDR R5 in E, dependent in D, br_taken_e=1 the same cycle -> stall_d=0, flush_d=1, flush_e=1. The next cycle has no stall.
- Assert reset during a load-use stall -> outputs 0 the same cycle. After release, a dependent ADD gets fwd_sel=0 and there is no stall. With HAZ_PERF_CNT_EN, the counters read 0.
